// File: rtl/mp_fifo_pkg.sv
// Shared helpers for the multi-port FIFO slice: width arithmetic for lane counts.
package mp_fifo_pkg;

  // Bits needed to hold a leading-ones count of 0..n over an n-lane vector.
  function automatic int unsigned lane_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mp_fifo_if.sv
// Enqueue/dequeue handshake bundle for mp_fifo; master drives requests, slave is the FIFO.
interface mp_fifo_if
  import mp_fifo_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = 8,
  parameter int unsigned ENTRY_WIDTH = 32,
  parameter int unsigned N_ENQ       = 2,
  parameter int unsigned N_DEQ       = 2
);
  localparam int unsigned CNT_WIDTH = $clog2(N_ENTRIES) + 1;

  logic [N_ENQ-1:0]                  enq_valid;
  logic [N_ENQ-1:0]                  enq_ready;
  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0] enq_data;
  logic [N_DEQ-1:0]                  deq_ready;
  logic [N_DEQ-1:0]                  deq_valid;
  logic [N_DEQ-1:0][ENTRY_WIDTH-1:0] deq_data;
  logic [CNT_WIDTH-1:0]              count;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count
  );

endinterface

// File: rtl/prefix_count.sv
// Counts the unbroken run of ones starting at bit 0 of bits_i.
module prefix_count
  import mp_fifo_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned CW = lane_cnt_width(N)
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] count_o
);

  // Stop counting at the first zero; later ones are ignored.
  always_comb begin
    logic run;
    run     = 1'b1;
    count_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      run = run & bits_i[i];
      if (run) count_o = count_o + CW'(1);
    end
  end

endmodule

// File: rtl/mp_fifo.sv
// Multi-port FIFO: N_ENQ writes and N_DEQ reads per cycle, wrap-around counters,
// all outputs derived from registered state only.
module mp_fifo
  import mp_fifo_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = 8,
  parameter int unsigned ENTRY_WIDTH = 32,
  parameter int unsigned N_ENQ       = 2,
  parameter int unsigned N_DEQ       = 2
) (
  input  logic     clk,
  input  logic     rst_aL,
  input  logic     flush,
  mp_fifo_if.slave bus
);
  localparam int unsigned PTR_WIDTH = $clog2(N_ENTRIES);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
  localparam int unsigned ENQ_CW    = lane_cnt_width(N_ENQ);
  localparam int unsigned DEQ_CW    = lane_cnt_width(N_DEQ);

  logic [CNT_WIDTH-1:0] enq_ctr_q, enq_ctr_d;
  logic [CNT_WIDTH-1:0] deq_ctr_q, deq_ctr_d;
  logic [CNT_WIDTH-1:0] count, free;
  logic [PTR_WIDTH-1:0] enq_ptr, deq_ptr;

  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] mem_q;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] mem_wdata;
  logic [N_ENTRIES-1:0]                  mem_we;

  logic [N_ENQ-1:0]                  enq_ready, enq_fire;
  logic [N_DEQ-1:0]                  deq_valid, deq_fire;
  logic [N_DEQ-1:0][ENTRY_WIDTH-1:0] deq_data;
  logic [ENQ_CW-1:0]                 n_enq;
  logic [DEQ_CW-1:0]                 n_deq;

  assign count   = enq_ctr_q - deq_ctr_q;
  assign free    = CNT_WIDTH'(N_ENTRIES) - count;
  assign enq_ptr = enq_ctr_q[PTR_WIDTH-1:0];
  assign deq_ptr = deq_ctr_q[PTR_WIDTH-1:0];

  // Per-lane grant/availability and read-port data from registered occupancy.
  always_comb begin
    logic [PTR_WIDTH-1:0] rd_slot;
    rd_slot = '0;
    for (int unsigned i = 0; i < N_ENQ; i++) begin
      enq_ready[i] = free > CNT_WIDTH'(i);
    end
    for (int unsigned j = 0; j < N_DEQ; j++) begin
      rd_slot     = deq_ptr + PTR_WIDTH'(j);
      deq_valid[j] = count > CNT_WIDTH'(j);
      deq_data[j]  = mem_q[rd_slot];
    end
  end

  assign enq_fire = bus.enq_valid & enq_ready;
  assign deq_fire = bus.deq_ready & deq_valid;

  prefix_count #(.N(N_ENQ)) u_enq_prefix (.bits_i(enq_fire), .count_o(n_enq));
  prefix_count #(.N(N_DEQ)) u_deq_prefix (.bits_i(deq_fire), .count_o(n_deq));

  // Route each accepted lane to its slot; lanes map to distinct slots, wrapping at N_ENTRIES.
  always_comb begin
    logic [PTR_WIDTH-1:0] wr_slot;
    wr_slot   = '0;
    mem_we    = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < N_ENQ; i++) begin
      wr_slot = enq_ptr + PTR_WIDTH'(i);
      if (i < 32'(n_enq)) begin
        mem_we[wr_slot]    = 1'b1;
        mem_wdata[wr_slot] = bus.enq_data[i];
      end
    end
  end

  assign enq_ctr_d = enq_ctr_q + CNT_WIDTH'(n_enq);
  assign deq_ctr_d = deq_ctr_q + CNT_WIDTH'(n_deq);

  // Counters: reset beats flush, flush discards the cycle's traffic.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      enq_ctr_q <= '0;
      deq_ctr_q <= '0;
    end else if (flush) begin
      enq_ctr_q <= '0;
      deq_ctr_q <= '0;
    end else begin
      enq_ctr_q <= enq_ctr_d;
      deq_ctr_q <= deq_ctr_d;
    end
  end

  // Per-entry storage registers; contents are not cleared by reset or flush.
  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < N_ENTRIES; e++) begin
      if (rst_aL && !flush && mem_we[e]) mem_q[e] <= mem_wdata[e];
    end
  end

  assign bus.enq_ready = enq_ready;
  assign bus.deq_valid = deq_valid;
  assign bus.deq_data  = deq_data;
  assign bus.count     = count;

endmodule

// File: tb/tb_mp_fifo.sv
// Self-checking bench for mp_fifo: queue reference model plus directed literal checks.
module tb_mp_fifo;
  localparam int unsigned NE = 8;
  localparam int unsigned EW = 32;
  localparam int unsigned NQ = 2;
  localparam int unsigned ND = 2;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mp_fifo_if #(.N_ENTRIES(NE), .ENTRY_WIDTH(EW), .N_ENQ(NQ), .N_DEQ(ND)) bus ();

  mp_fifo #(.N_ENTRIES(NE), .ENTRY_WIDTH(EW), .N_ENQ(NQ), .N_DEQ(ND)) dut (
    .clk   (clk),
    .rst_aL(rst_aL),
    .flush (flush),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  bit model_ok = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare DUT against the model, then advance the model.
  task automatic step(input bit r, input bit f, input logic [1:0] ev,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] dr);
    int unsigned sz;
    int n_enq, n_deq;
    logic [31:0] din[2];
    @(negedge clk);
    rst_aL = r;
    flush  = f;
    bus.enq_valid   = ev;
    bus.enq_data[0] = d0;
    bus.enq_data[1] = d1;
    bus.deq_ready   = dr;
    din[0] = d0;
    din[1] = d1;
    #1;
    sz = q.size();
    if (model_ok) begin
      chk("count", 64'(bus.count), 64'(sz));
      for (int i = 0; i < NQ; i++)
        chk($sformatf("enq_ready[%0d]", i), 64'(bus.enq_ready[i]), 64'((NE - sz) > i));
      for (int j = 0; j < ND; j++) begin
        chk($sformatf("deq_valid[%0d]", j), 64'(bus.deq_valid[j]), 64'(sz > j));
        if (sz > j) chk($sformatf("deq_data[%0d]", j), 64'(bus.deq_data[j]), 64'(q[j]));
      end
    end
    n_enq = 0;
    while (n_enq < NQ && ev[n_enq] && (NE - sz) > n_enq) n_enq++;
    n_deq = 0;
    while (n_deq < ND && dr[n_deq] && sz > n_deq) n_deq++;
    if (!r) begin
      q.delete();
      model_ok = 1'b1;
    end else if (f) begin
      q.delete();
    end else begin
      repeat (n_deq) void'(q.pop_front());
      for (int i = 0; i < n_enq; i++) q.push_back(din[i]);
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'b00, '0, '0, 2'b00);
  endtask

  task automatic enq(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1);
    step(1'b1, 1'b0, ev, d0, d1, 2'b00);
  endtask

  task automatic deq(input logic [1:0] dr);
    step(1'b1, 1'b0, 2'b00, '0, '0, dr);
  endtask

  initial begin
    bus.enq_valid = '0;
    bus.enq_data  = '0;
    bus.deq_ready = '0;

    // Reset state
    step(1'b0, 1'b0, 2'b00, '0, '0, 2'b00);
    idle();
    chk("reset count", 64'(bus.count), 64'd0);
    chk("reset deq_valid", 64'(bus.deq_valid), 64'b00);
    chk("reset enq_ready", 64'(bus.enq_ready), 64'b11);

    // Two-lane enqueue visible the following cycle in lane order
    enq(2'b11, 32'hA000_0000, 32'hA000_0001);
    idle();
    chk("dual count", 64'(bus.count), 64'd2);
    chk("dual deq_valid", 64'(bus.deq_valid), 64'b11);
    chk("dual deq_data0", 64'(bus.deq_data[0]), 64'hA000_0000);
    chk("dual deq_data1", 64'(bus.deq_data[1]), 64'hA000_0001);

    // Fill to 7, then only lane 0 may enter
    enq(2'b11, 32'h1111_0002, 32'h1111_0003);
    enq(2'b11, 32'h1111_0004, 32'h1111_0005);
    enq(2'b01, 32'h1111_0006, 32'h0);
    enq(2'b11, 32'hB000_0000, 32'hB000_0001);
    chk("near-full enq_ready", 64'(bus.enq_ready), 64'b01);
    idle();
    chk("full count", 64'(bus.count), 64'd8);
    chk("full enq_ready", 64'(bus.enq_ready), 64'b00);

    // Drain to 3, then lane-1-only request is refused by the prefix rule
    deq(2'b11);
    deq(2'b11);
    deq(2'b01);
    enq(2'b10, 32'hDEAD_0000, 32'hDEAD_0001);
    idle();
    chk("prefix count", 64'(bus.count), 64'd3);

    // Position enq_ptr=7, deq_ptr=6, count=1, then enqueue two across the wrap
    step(1'b1, 1'b1, 2'b00, '0, '0, 2'b00);
    enq(2'b11, 32'hD000_0000, 32'hD000_0001);
    enq(2'b11, 32'hD000_0002, 32'hD000_0003);
    enq(2'b11, 32'hD000_0004, 32'hD000_0005);
    enq(2'b01, 32'hD000_0006, 32'h0);
    deq(2'b11);
    deq(2'b11);
    deq(2'b11);
    step(1'b1, 1'b0, 2'b11, 32'hC000_0000, 32'hC000_0001, 2'b11);
    chk("wrap pre deq_valid", 64'(bus.deq_valid), 64'b01);
    chk("wrap pre deq_data0", 64'(bus.deq_data[0]), 64'hD000_0006);
    idle();
    chk("wrap count", 64'(bus.count), 64'd2);
    chk("wrap deq_data0", 64'(bus.deq_data[0]), 64'hC000_0000);
    chk("wrap deq_data1", 64'(bus.deq_data[1]), 64'hC000_0001);

    // Flush with concurrent enqueue at count 5
    enq(2'b11, 32'hE000_0000, 32'hE000_0001);
    enq(2'b01, 32'hE000_0002, 32'h0);
    step(1'b1, 1'b1, 2'b11, 32'hF000_0000, 32'hF000_0001, 2'b00);
    idle();
    chk("flush count", 64'(bus.count), 64'd0);
    chk("flush deq_valid", 64'(bus.deq_valid), 64'b00);

    // Reset mid-operation
    enq(2'b11, 32'h2000_0000, 32'h2000_0001);
    enq(2'b01, 32'h2000_0002, 32'h0);
    step(1'b0, 1'b0, 2'b11, 32'h3000_0000, 32'h3000_0001, 2'b11);
    idle();
    chk("midreset count", 64'(bus.count), 64'd0);
    chk("midreset deq_valid", 64'(bus.deq_valid), 64'b00);
    chk("midreset enq_ready", 64'(bus.enq_ready), 64'b11);

    // Random traffic against the queue model
    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 499) != 0, $urandom_range(0, 63) == 0,
           2'($urandom), $urandom, $urandom, 2'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
